// File: rtl/period_meter_if.sv
// Result handshake between period_meter (master) and its consumer (slave).
// periodOut/periodValid travel from the meter; periodReady returns from the consumer.
interface period_meter_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [COUNT_WIDTH-1:0] periodOut;
  logic                   periodValid;
  logic                   periodReady;

  modport master (
    output periodOut,
    output periodValid,
    input  periodReady
  );

  modport slave (
    input  periodOut,
    input  periodValid,
    output periodReady
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures the rising-edge period of an asynchronous tick input in
// clockIn cycles and delivers each result over a valid/ready handshake.
// Optional feature macro: PERIOD_MINMAX_EN adds minPeriod/maxPeriod tracking outputs.
module period_meter #(
  parameter int          COUNT_WIDTH = 32,
  parameter int unsigned TIMEOUT     = 200000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clockIn,
  input  logic                   resetN,
  input  logic                   tickIn,
  input  logic                   enable,
  period_meter_if.master         res,
  output logic                   timeoutFlag,
  output logic                   overrun
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [COUNT_WIDTH-1:0] minPeriod,
  output logic [COUNT_WIDTH-1:0] maxPeriod
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_TOUT    = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] C_TIMEOUT = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] C_ONE     = COUNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   w_rise;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   w_at_limit;
  logic                   w_load;
  logic                   r_timeout;
  logic                   w_timeout_next;

  logic [COUNT_WIDTH-1:0] r_period;
  logic                   r_valid;
  logic                   r_overrun;

  // Synchronize the asynchronous tick and keep one extra flop of history for edge detect.
  // NOTE: every clocked process uses non-blocking assignments so all flops sample
  // pre-edge values; blocking here would collapse the synchronizer chain into one flop.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], tickIn};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_at_limit = (r_count == C_TIMEOUT);

  // FSM state register.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM next-state logic; dropping enable always returns to IDLE.
  // NOTE: each always_comb output gets a default on its first line so no path can
  // leave it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_ARM;
        S_ARM:     if (w_rise) w_state_next = S_MEASURE;
        S_MEASURE: if (!w_rise && w_at_limit) w_state_next = S_TOUT;
        S_TOUT:    if (w_rise) w_state_next = S_MEASURE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: counter update, result load strobe and timeout flag update.
  always_comb begin
    w_count_next   = r_count;
    w_load         = 1'b0;
    w_timeout_next = r_timeout;
    if (!enable) begin
      w_count_next   = '0;
      w_timeout_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_count_next   = '0;
          w_timeout_next = 1'b0;
        end
        S_ARM: begin
          // First edge only starts the interval; it carries no result.
          if (w_rise) w_count_next = C_ONE;
        end
        S_MEASURE: begin
          if (w_rise) begin
            w_count_next = C_ONE;
            w_load       = 1'b1;
          end else if (w_at_limit) begin
            // Counter holds at TIMEOUT, so it can never wrap.
            w_timeout_next = 1'b1;
          end else begin
            w_count_next = r_count + C_ONE;
          end
        end
        S_TOUT: begin
          // The stalled interval is discarded; the edge restarts measurement.
          if (w_rise) begin
            w_count_next   = C_ONE;
            w_timeout_next = 1'b0;
          end
        end
        default: begin
          w_count_next   = '0;
          w_timeout_next = 1'b0;
        end
      endcase
    end
  end

  // Period counter and timeout flag registers.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_timeout <= w_timeout_next;
    end
  end

  // Result register and handshake: a load wins over a same-cycle transfer, and
  // a load onto an unaccepted result marks overrun until enable drops.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_period <= r_count;
        r_valid  <= 1'b1;
      end else if (r_valid && res.periodReady) begin
        r_valid <= 1'b0;
      end

      if (!enable)                                      r_overrun <= 1'b0;
      else if (w_load && r_valid && !res.periodReady)   r_overrun <= 1'b1;
    end
  end

`ifdef PERIOD_MINMAX_EN
  logic [COUNT_WIDTH-1:0] r_min;
  logic [COUNT_WIDTH-1:0] r_max;

  // Track extreme periods over all loaded results since reset or enable drop.
  always_ff @(posedge clockIn or negedge resetN) begin
    if (!resetN) begin
      r_min <= '1;
      r_max <= '0;
    end else if (!enable) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_load) begin
      if (r_count < r_min) r_min <= r_count;
      if (r_count > r_max) r_max <= r_count;
    end
  end

  assign minPeriod = r_min;
  assign maxPeriod = r_max;
`endif

  assign res.periodOut   = r_period;
  assign res.periodValid = r_valid;
  assign timeoutFlag     = r_timeout;
  assign overrun         = r_overrun;

endmodule
